key_schedule_rev: RTL
=====================

Name: key_schedule_rev

Overview:
- Reverse-direction Simon 64/128 round-key generator for the decryption datapath.
- Loads the last four round keys, k[ROUNDS-1]..k[ROUNDS-4], left behind by the forward key schedule.
- Emits round keys in descending order, k[ROUNDS-1] down to k[0], over a valid/ready stream.
- Runs the forward recurrence backwards, so the full key table is never stored.

Parameters:
- WORD, 32, key word width in bits.
- ROUNDS, 44, number of round keys. Legal range 5..66.
- M, 4, key words in the window. Fixed at 4 (Simon 64/128).

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  load request. Accepted only in IDLE.
- k_last0  input  WORD  k[ROUNDS-1].
- k_last1  input  WORD  k[ROUNDS-2].
- k_last2  input  WORD  k[ROUNDS-3].
- k_last3  input  WORD  k[ROUNDS-4].
- key_out  output  WORD  current round key.
- key_idx  output  8  round index of key_out.
- key_valid  output  1  key_out/key_idx are valid.
- key_ready  input  1  consumer accepts the key this cycle.
- busy  output  1  high from load until the final key is accepted.
- done  output  1  one-cycle pulse after k[0] is accepted.

Behaviour:
- Reset: asynchronous, active-low.
  - State goes to IDLE.
  - key_out=0, key_idx=0, key_valid=0, busy=0, done=0, window registers=0.
  - Reset mid-stream aborts the stream. No partial keys follow after rstn rises.
- Window registers w0..w3. While emitting k[j]: w0=k[j], w1=k[j-1], w2=k[j-2], w3=k[j-3].
- Output assignments: key_out=w0, key_idx=j.
- IDLE:
  - start=1 loads w0..w3 from k_last0..k_last3 and sets j=ROUNDS-1.
  - Moves to EMIT. busy=1 and key_valid=1 from the next cycle.
  - Latency start->first valid key: 1 cycle.
- EMIT:
  - key_valid=1 continuously.
  - key_out and key_idx hold stable while key_ready=0.
  - On key_valid&key_ready with j>0:
    - Shift: w0<=w1, w1<=w2, w2<=w3, w3<=knew. Then j<=j-1.
    - Throughput: 1 key/cycle while key_ready is held high.
  - On key_valid&key_ready with j==0:
    - Move to IDLE; key_valid=0 and busy=0 next cycle.
    - done=1 for exactly that next cycle.
- Backward step, computing knew=k[j-4], only meaningful for j>=4:
  - tmp = ror(w1,3) ^ w3
  - knew = w0 ^ C ^ z3[j-4] ^ tmp ^ ror(tmp,1)
  - C = 0xFFFFFFFC. z3 bit enters bit 0. ror is a rotate right.
  - For j<4, knew=0 (no key below k[0]).
- z3 is the 62-bit Simon z3 sequence 11110000101100111001010001001000000111101001100011010111011011. Bit index 0 is the leftmost character. Index is (j-4) mod 62.
- All arithmetic is modulo 2^WORD. Rotates are within WORD bits.
- start while busy is ignored. No restart and no reload.
- start and the final accept in the same cycle: the final accept completes; start is ignored. The next start is accepted in IDLE, the cycle after done.
- key_ready with key_valid=0 has no effect.

Decomposition:
- simon_pkg holds:
  - WORD, ROUNDS.
  - Z3 as a 62-bit localparam, string-ordered as above.
  - C_CONST=0xFFFFFFFC.
  - ror function.
  - State enum {IDLE, EMIT}.
- One sub-module, key_step_rev: combinational (w0, w1, w3, zbit) -> knew. It is shared with a future decryption core and testable in isolation against the forward recurrence.

Test Plan:
- Known vector: master key 1b1a1918 13121110 0b0a0908 03020100. A forward model supplies k[43..40]. start, key_ready=1. Required response:
  - 44 consecutive keys, idx 43..0.
  - Last four keys 1b1a1918, 13121110, 0b0a0908, 03020100.
  - done one cycle after idx 0.
- Backpressure: same vector, key_ready toggled randomly, with a 10-cycle stall at idx 20. Required response:
  - key_out/key_idx are stable during stalls.
  - The sequence is identical to the first test.
  - Exactly 44 handshakes.
- Reset mid-stream: rstn low for 2 cycles after idx 30 is accepted. Required response:
  - key_valid=0 and busy=0 immediately.
  - No keys until the next start.
  - A rerun gives the full correct sequence.
- start while busy: pulse start at idx 25 with different k_last values. Required response: the ignored stream continues unchanged; done fires once.
- Back-to-back: start asserted in the final-accept cycle and again in the done cycle. Required response: the first start is ignored; the second loads; first key_valid follows 1 cycle later.
- key_step_rev unit check: random w0/w1/w3/zbit. Required response: the forward recurrence applied to the output reproduces w0, for 10k vectors.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon 64/128 key schedule blocks.
// Contents: word/round sizing, the z3 constant sequence, the round
// constant C, a rotate-right helper, the z3 bit lookup and the FSM states.
package simon_pkg;

    localparam int WORD   = 32;
    localparam int ROUNDS = 44;
    localparam int M      = 4;

    // Written as the sequence reads left to right: sequence index 0 sits at bit 61.
    localparam logic [61:0] Z3 =
        62'b11110000101100111001010001001000000111101001100011010111011011;

    localparam logic [WORD-1:0] C_CONST = 32'hFFFF_FFFC;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    function automatic logic [WORD-1:0] ror(input logic [WORD-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD - n));
    endfunction

    // Sequence index -> z3 bit, with the index taken mod 62.
    function automatic logic z3_bit(input logic [7:0] idx);
        logic [7:0] m;
        logic [5:0] pos;
        m   = idx % 8'd62;
        pos = 6'(8'd61 - m);
        return Z3[pos];
    endfunction

endpackage

// File: rtl/key_step_rev.sv
// One backward step of the Simon 64/128 key recurrence.
// Given the window w0=k[j], w1=k[j-1], w3=k[j-3] and the z3 bit for
// index j-4, produces knew=k[j-4].
// Ports:
//   w0, w1, w3 : window words (WORD bits)
//   zbit       : z3 sequence bit for index j-4
//   knew       : recovered key k[j-4]
module key_step_rev
    import simon_pkg::*;
(
    input  logic [WORD-1:0] w0,
    input  logic [WORD-1:0] w1,
    input  logic [WORD-1:0] w3,
    input  logic            zbit,
    output logic [WORD-1:0] knew
);

    logic [WORD-1:0] tmp;

    // Forward step is k[j] = k[j-4] ^ C ^ z ^ f(k[j-1], k[j-3]);
    // all terms are XORed, so the same expression recovers k[j-4].
    always_comb begin
        tmp  = ror(w1, 3) ^ w3;
        knew = w0 ^ C_CONST ^ {{(WORD-1){1'b0}}, zbit} ^ tmp ^ ror(tmp, 1);
    end

endmodule

// File: rtl/key_schedule_rev.sv
// Reverse-direction Simon 64/128 round-key generator.
// Loads the last four forward round keys and streams k[ROUNDS-1] .. k[0]
// over a valid/ready interface, regenerating older keys on the fly.
// Ports:
//   clk, rstn            : clock (rising edge), async active-low reset
//   start                : load request, honoured only in IDLE
//   k_last0..k_last3     : k[ROUNDS-1] .. k[ROUNDS-4]
//   key_out, key_idx     : current round key and its index
//   key_valid, key_ready : stream handshake
//   busy                 : high from load until k[0] is accepted
//   done                 : one-cycle pulse after k[0] is accepted
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// EMIT  | presenting k[j]; shifts the window on each accepted key
module key_schedule_rev
    import simon_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [WORD-1:0] k_last0,
    input  logic [WORD-1:0] k_last1,
    input  logic [WORD-1:0] k_last2,
    input  logic [WORD-1:0] k_last3,
    output logic [WORD-1:0] key_out,
    output logic [7:0]      key_idx,
    output logic            key_valid,
    input  logic            key_ready,
    output logic            busy,
    output logic            done
);

    state_t          state;
    logic [WORD-1:0] w0, w1, w2, w3;
    logic [7:0]      j;
    logic [7:0]      zidx;
    logic            zbit;
    logic [WORD-1:0] knew_raw;
    logic [WORD-1:0] knew;

    assign zidx = j - 8'd4;
    assign zbit = (j >= 8'd4) ? z3_bit(zidx) : 1'b0;

    key_step_rev u_step (
        .w0   (w0),
        .w1   (w1),
        .w3   (w3),
        .zbit (zbit),
        .knew (knew_raw)
    );

    // Nothing exists below k[0]; feed zeros into the tail of the window.
    assign knew = (j >= 8'd4) ? knew_raw : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            w0        <= '0;
            w1        <= '0;
            w2        <= '0;
            w3        <= '0;
            j         <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        w0        <= k_last0;
                        w1        <= k_last1;
                        w2        <= k_last2;
                        w3        <= k_last3;
                        j         <= 8'(ROUNDS - 1);
                        key_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (key_ready) begin
                        if (j != 8'd0) begin
                            w0 <= w1;
                            w1 <= w2;
                            w2 <= w3;
                            w3 <= knew;
                            j  <= j - 8'd1;
                        end else begin
                            key_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign key_out = w0;
    assign key_idx = j;

endmodule
